// File: rtl/dac_pkg.sv
// Shared constants and state type for the serial DAC path.
package dac_pkg;

  localparam logic [3:0]  CMD_WRITE_UPDATE = 4'b0011;
  localparam logic [3:0]  ADDR_ALL         = 4'b1111;
  localparam int unsigned FRAME_BITS       = 32;
  localparam logic [11:0] MIDSCALE         = 12'h800;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

endpackage

// File: rtl/dac_spi_serializer.sv
// Sample hold register plus SPI frame shifter for an LTC2624-style DAC.
module dac_spi_serializer #(
  parameter int unsigned       DATA_W     = 12,
  parameter int unsigned       FRAME_BITS = dac_pkg::FRAME_BITS,
  parameter logic [3:0]        CMD        = dac_pkg::CMD_WRITE_UPDATE,
  parameter logic [3:0]        ADDR       = dac_pkg::ADDR_ALL,
  parameter logic [DATA_W-1:0] MIDSCALE   = dac_pkg::MIDSCALE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sound_load,
  input  logic              DAC_load,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              spi_sck,
  output logic              spi_mosi,
  output logic              dac_cs_n,
  output logic              frame_done,
  output logic              underrun,
  output logic              overrun
);

  import dac_pkg::*;

  localparam int unsigned            CNT_W    = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0]       LAST_BIT = CNT_W'(FRAME_BITS - 1);

  state_e                  state_q, state_d;
  logic                    phase_q, phase_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic [DATA_W-1:0]       hold_q, hold_d;
  logic                    sck_q, sck_d;
  logic                    mosi_q, mosi_d;
  logic                    cs_n_q, cs_n_d;
  logic                    frame_done_q, frame_done_d;
  logic                    underrun_q, underrun_d;
  logic                    overrun_q, overrun_d;
  logic [FRAME_BITS-1:0]   frame_word;

  assign sample_ready = sound_load;
  assign spi_sck      = sck_q;
  assign spi_mosi     = mosi_q;
  assign dac_cs_n     = cs_n_q;
  assign frame_done   = frame_done_q;
  assign underrun     = underrun_q;
  assign overrun      = overrun_q;

  // Next-state: hold register, frame FSM and the registered SPI pins.
  // Pin values are computed for the cycle being entered, so the flops present
  // bit k from DAC_load+1+2k with no extra pipeline stage.
  always_comb begin
    frame_word   = {8'h00, CMD, ADDR, hold_q, 4'h0};
    hold_d       = hold_q;
    underrun_d   = sound_load && !sample_valid;
    overrun_d    = 1'b0;
    state_d      = state_q;
    phase_d      = phase_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    sck_d        = 1'b0;
    mosi_d       = 1'b0;
    cs_n_d       = 1'b1;
    frame_done_d = 1'b0;

    if (sound_load && sample_valid) begin
      hold_d = sample_in;
    end

    case (state_q)
      IDLE: begin
        if (DAC_load) begin
          state_d   = SHIFT;
          phase_d   = 1'b0;
          bit_cnt_d = '0;
          shreg_d   = frame_word;
          cs_n_d    = 1'b0;
          mosi_d    = frame_word[FRAME_BITS-1];
        end
      end
      SHIFT: begin
        overrun_d = DAC_load;
        cs_n_d    = 1'b0;
        if (!phase_q) begin
          phase_d = 1'b1;
          sck_d   = 1'b1;
          mosi_d  = mosi_q;
        end else if (bit_cnt_q == LAST_BIT) begin
          state_d      = IDLE;
          phase_d      = 1'b0;
          cs_n_d       = 1'b1;
          frame_done_d = 1'b1;
        end else begin
          phase_d   = 1'b0;
          shreg_d   = {shreg_q[FRAME_BITS-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          mosi_d    = shreg_q[FRAME_BITS-2];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      phase_q      <= 1'b0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      hold_q       <= MIDSCALE;
      sck_q        <= 1'b0;
      mosi_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      hold_q       <= hold_d;
      sck_q        <= sck_d;
      mosi_q       <= mosi_d;
      cs_n_q       <= cs_n_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
      overrun_q    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_dac_spi_serializer.sv
// Self-checking bench: cycle-offset reference model plus directed frame checks.
module tb_dac_spi_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sound_load = 1'b0;
  logic        DAC_load = 1'b0;
  logic        sample_valid = 1'b0;
  logic [11:0] sample_in = '0;
  logic        sample_ready, spi_sck, spi_mosi, dac_cs_n, frame_done, underrun, overrun;

  always #5 clk = ~clk;

  dac_spi_serializer #(
    .DATA_W    (12),
    .FRAME_BITS(32),
    .CMD       (4'b0011),
    .ADDR      (4'b1111),
    .MIDSCALE  (12'h800)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sound_load  (sound_load),
    .DAC_load    (DAC_load),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .dac_cs_n    (dac_cs_n),
    .frame_done  (frame_done),
    .underrun    (underrun),
    .overrun     (overrun)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          tcyc  = 0;

  always @(posedge clk) tcyc++;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, tcyc, act, exp);
    end
  endfunction

  // Reference model: a frame is described only by its start cycle and word.
  bit          m_known = 1'b0;
  bit          s_valid = 1'b0;
  int          s_cyc   = 0;
  logic [31:0] m_word  = '0;
  logic [11:0] m_hold  = 12'h800;
  bit          m_under = 1'b0;
  bit          m_over  = 1'b0;

  // Capture of what a real DAC would see.
  logic [31:0] cap = '0;
  logic [31:0] last_frame = '0;
  logic        prev_mosi = 1'b0;
  int          nbits = 0, last_bits = 0, cs_low = 0, last_cs_low = 0;
  int          frames = 0, done_cyc = 0, under_cnt = 0, over_cnt = 0, over_cyc = 0;

  always @(negedge clk) begin
    int d;
    int idx;
    bit act;
    bit busy;
    logic [6:0] ev;
    logic [6:0] av;

    if (m_known) begin
      d   = s_valid ? tcyc - s_cyc : -1;
      act = s_valid && d >= 1 && d <= 64;
      idx = act ? 31 - (d - 1) / 2 : 0;
      ev  = {sound_load, !act, act && ((d - 1) % 2 == 1), act ? m_word[idx] : 1'b0,
             s_valid && d == 65, m_under, m_over};
      av  = {sample_ready, dac_cs_n, spi_sck, spi_mosi, frame_done, underrun, overrun};
      chk("outputs{rdy,cs_n,sck,mosi,done,under,over}", 32'(av), 32'(ev));
    end

    if (dac_cs_n === 1'b0 && spi_sck === 1'b0) prev_mosi = spi_mosi;
    if (dac_cs_n === 1'b0 && spi_sck === 1'b1) begin
      chk("mosi_stable", 32'(spi_mosi), 32'(prev_mosi));
      cap = {cap[30:0], spi_mosi};
      nbits++;
    end
    if (dac_cs_n === 1'b0) cs_low++;
    if (frame_done === 1'b1) begin
      last_frame  = cap;
      last_bits   = nbits;
      last_cs_low = cs_low;
      done_cyc    = tcyc;
      frames++;
    end
    if (dac_cs_n !== 1'b0) begin
      nbits  = 0;
      cs_low = 0;
    end
    if (underrun === 1'b1) under_cnt++;
    if (overrun === 1'b1) begin
      over_cnt++;
      over_cyc = tcyc;
    end

    if (rst) begin
      m_known = 1'b1;
      s_valid = 1'b0;
      m_hold  = 12'h800;
      m_under = 1'b0;
      m_over  = 1'b0;
    end else if (m_known) begin
      busy    = s_valid && (tcyc - s_cyc) >= 1 && (tcyc - s_cyc) <= 64;
      m_over  = DAC_load && busy;
      m_under = sound_load && !sample_valid;
      if (DAC_load && !busy) begin
        s_valid = 1'b1;
        s_cyc   = tcyc;
        m_word  = {8'h00, 4'h3, 4'hF, m_hold, 4'h0};
      end
      if (sound_load && sample_valid) m_hold = sample_in;
    end
  end

  task automatic tick(input logic sl, input logic sv, input logic dl, input logic r,
                      input logic [11:0] d);
    @(posedge clk);
    #1;
    sound_load   = sl;
    sample_valid = sv;
    DAC_load     = dl;
    rst          = r;
    sample_in    = d;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 12'($urandom));
  endtask

  int n0, f0, u0, o0;

  initial begin
    tick(1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
    idle(3);
    chk("reset_cs_n", 32'(dac_cs_n), 32'd1);
    chk("reset_sck_mosi", 32'({spi_sck, spi_mosi}), 32'd0);
    chk("reset_pulses", 32'({frame_done, underrun, overrun}), 32'd0);

    // Midscale frame with no samples ever loaded.
    tick(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    n0 = tcyc;
    idle(70);
    chk("midscale_frame", last_frame, 32'h003F_8000);
    chk("midscale_bits", 32'(last_bits), 32'd32);
    chk("cs_low_cycles", 32'(last_cs_low), 32'd64);
    chk("done_latency", 32'(done_cyc - n0), 32'd65);
    chk("frame_count", 32'(frames), 32'd1);

    // Valid sample then frame.
    tick(1'b1, 1'b1, 1'b0, 1'b0, 12'hABC);
    idle(2);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    idle(70);
    chk("abc_frame", last_frame, 32'h003F_ABC0);

    // Simultaneous sound_load and DAC_load: old hold goes out, new one next.
    tick(1'b1, 1'b1, 1'b1, 1'b0, 12'h555);
    idle(70);
    chk("simul_old_frame", last_frame, 32'h003F_ABC0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    idle(70);
    chk("simul_new_frame", last_frame, 32'h003F_5550);

    // Underrun keeps the previous sample.
    tick(1'b1, 1'b1, 1'b0, 1'b0, 12'h123);
    u0 = under_cnt;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 12'hFFF);
    idle(2);
    chk("underrun_count", 32'(under_cnt - u0), 32'd1);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    idle(70);
    chk("underrun_frame", last_frame, 32'h003F_1230);

    // DAC_load re-asserted mid-frame.
    tick(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    n0 = tcyc;
    o0 = over_cnt;
    idle(9);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    idle(70);
    chk("overrun_count", 32'(over_cnt - o0), 32'd1);
    chk("overrun_cycle", 32'(over_cyc - n0), 32'd11);
    chk("overrun_frame", last_frame, 32'h003F_1230);
    chk("overrun_done_latency", 32'(done_cyc - n0), 32'd65);

    // Reset mid-frame abandons it; hold returns to midscale.
    tick(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    f0 = frames;
    idle(19);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
    idle(1);
    chk("midreset_cs_sck", 32'({dac_cs_n, spi_sck}), 32'b10);
    idle(70);
    chk("midreset_no_done", 32'(frames - f0), 32'd0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    idle(70);
    chk("after_reset_frame", last_frame, 32'h003F_8000);

    // Generator-like cadence: one sample and one frame per 1135 cycles.
    f0 = frames;
    o0 = over_cnt;
    for (int unsigned i = 0; i < 5; i++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0, 12'($urandom));
      tick(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
      idle(1133);
    end
    chk("gen_frames", 32'(frames - f0), 32'd5);
    chk("gen_no_overrun", 32'(over_cnt - o0), 32'd0);

    // Random traffic checked cycle by cycle against the model.
    for (int unsigned i = 0; i < 4000; i++) begin
      tick(($urandom % 8) == 0, ($urandom % 4) != 0, ($urandom % 50) == 0,
           ($urandom % 600) == 0, 12'($urandom));
    end
    idle(70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
